life_core: RTL
==============

# life_core

Double-buffered Game of Life cell engine that sits directly upstream of the VGA timing stage. It holds the N×M cell grid and answers the display's per-pixel cell-index read with a registered `vga_live` bit. On request, it computes the next generation into a shadow bank one cell per clock, with toroidal wrap. It then swaps banks atomically, so the display never shows a half-updated frame.

## Interface

**Parameters**
- `WIDTH`, default 12. The read index `pos` is `2*WIDTH` bits wide, matching the VGA stage.
- `P_PARAM_N`, default 8. Grid extent in y, and the index stride.
- `P_PARAM_M`, default 8. Grid extent in x.
- `GEN_W`, default 16. Width of the generation counter.

**Ports**
- `clk`  in  1  single clock.
- `reset`  in  1  reset, synchronous, active-high.
- `pos`  in  2*WIDTH  display read index, `x*P_PARAM_N + y`.
- `vga_live`  out  1  state of cell `pos` in the displayed bank.
- `step`  in  1  request one generation update; pulse or level.
- `load_en`  in  1  write one cell of the displayed bank.
- `load_pos`  in  2*WIDTH  write index, same mapping as `pos`.
- `load_val`  in  1  value to write.
- `busy`  out  1  high while an update is in progress.
- `done`  out  1  one-cycle pulse when a new generation becomes visible.
- `generation`  out  GEN_W  count of completed updates since reset.

## Operation

**Storage and indexing**
- Two banks of `P_PARAM_N*P_PARAM_M` bits.
- `disp_sel` picks the displayed bank; the other bank is the shadow.
- Cell (x, y) has x in [0, M) and y in [0, N), at index `x*P_PARAM_N + y`.

**FSM: IDLE → COMPUTE → SWAP → IDLE**
- **IDLE**
  - `load_en` with `load_pos < N*M` writes `load_val` into the displayed bank.
  - Otherwise, `step` starts an update: `idx` ← 0, go to COMPUTE.
  - If `load_en` and `step` are high in the same cycle, the load is performed and `step` is ignored that cycle.
- **COMPUTE**
  - For cell `idx`, count its 8 neighbours from the displayed bank with toroidal wrap: x−1 of 0 is M−1, x+1 of M−1 is 0, and likewise for y.
  - Next state = (count == 3) OR (alive AND count == 2). Write it to the shadow bank at `idx`.
  - `idx` increments; after `idx == N*M−1`, go to SWAP.
  - Neighbour count is 4 bits, with no saturation needed.
- **SWAP**
  - Toggle `disp_sel`.
  - `generation` ← `generation + 1`, wrapping modulo 2^GEN_W.
  - Go to IDLE.

**Ignored requests**
- `step` and `load_en` are ignored while `busy` is high; they are not queued.
- A `load_pos` ≥ N*M is ignored.

**Display reads**
- Reads always use the displayed bank, including during COMPUTE.
- `pos` ≥ N*M reads as 0.

## Timing

**Reset values**
- Both banks all 0.
- `disp_sel` 0, state IDLE, `idx` 0.
- `vga_live` 0, `busy` 0, `done` 0, `generation` 0.
- Reset asserted mid-COMPUTE or mid-SWAP aborts the update and clears everything on that edge.

**Latencies**
- `vga_live` is registered: the value for `pos` sampled at edge k appears after edge k. This is a 1-cycle read latency, which the VGA stage already absorbs.
- A load at edge k is visible to a read of the same index sampled at edge k+1.
- An accepted `step` at edge k gives:
  - `busy` = 1 from after edge k, for N*M+1 cycles (COMPUTE plus SWAP).
  - `disp_sel` toggles at edge k+N*M+1.
  - `generation` increments at edge k+N*M+1.
  - `done` = 1 for exactly the cycle after edge k+N*M+1.
  - `busy` = 0 after edge k+N*M+1.
- `busy` is decoded from state (state ≠ IDLE). `done` is a register.
- A `step` held high re-triggers in the first IDLE cycle, giving back-to-back generations every N*M+2 cycles.

## Test plan

Defaults throughout: N = M = 8.

1. **Blinker.** Load indices 26, 27, 28, then pulse `step`.
   - After `done`: exactly 19, 27, 35 are live, `generation` = 1.
   - A second step restores 26, 27, 28 with `generation` = 2.
2. **Wrap still life.** Load the corners 0, 7, 56, 63 and step 3 times.
   - The grid is unchanged after each step, which proves toroidal wrap.
   - A lone cell at index 0 dies after 1 step.
3. **Busy, done and display stability.**
   - `step` at edge k: `busy` is high for exactly 65 cycles and `done` pulses once, in the cycle after edge k+65.
   - Reads during COMPUTE return the old generation.
   - A `load_en` issued mid-COMPUTE has no effect.
4. **Read bounds and latency.**
   - `pos` = 63 live returns `vga_live` = 1 one cycle later.
   - `pos` = 64 and `pos` = 4095 return 0.
5. **Reset mid-update.** Load the blinker, step, then assert `reset` 20 cycles later.
   - The next cycle has `busy` = 0, `generation` = 0 and all reads 0.
   - A subsequent `step` on the empty grid leaves it empty.
6. **Load/step collision.** `load_en` and `step` are high in the same IDLE cycle.
   - The cell is written and `busy` stays 0.
   - `step` on the next cycle starts the update.

Source files
------------

// File: rtl/life_if.sv
// Display/control bus between the VGA stage (master) and the life cell engine (slave).
interface life_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned GEN_W = 16
) ();
  logic [2*WIDTH-1:0] pos;
  logic               vga_live;
  logic               step;
  logic               load_en;
  logic [2*WIDTH-1:0] load_pos;
  logic               load_val;
  logic               busy;
  logic               done;
  logic [GEN_W-1:0]   generation;

  modport master (
    output pos, step, load_en, load_pos, load_val,
    input  vga_live, busy, done, generation
  );

  modport slave (
    input  pos, step, load_en, load_pos, load_val,
    output vga_live, busy, done, generation
  );
endinterface

// File: rtl/life_core.sv
// Double-buffered Game of Life engine: serves registered display reads from one bank while
// computing the next generation into the other, one cell per clock, then swaps banks.
module life_core #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned P_PARAM_N = 8,
  parameter int unsigned P_PARAM_M = 8,
  parameter int unsigned GEN_W     = 16
) (
  input logic   clk,
  input logic   reset,
  life_if.slave bus
);
  localparam int unsigned Cells = P_PARAM_N * P_PARAM_M;
  localparam int unsigned IdxW  = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned XW    = (P_PARAM_M > 1) ? $clog2(P_PARAM_M) : 1;
  localparam int unsigned YW    = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [PW-1:0] CellsP = PW'(Cells);

  typedef enum logic [1:0] {StIdle, StCompute, StSwap} state_e;

  state_e           state_q, state_d;
  logic [Cells-1:0] bank_q [2];
  logic             disp_sel_q;
  logic [IdxW-1:0]  idx_q;
  logic [XW-1:0]    cx_q;
  logic [YW-1:0]    cy_q;
  logic [GEN_W-1:0] gen_q;
  logic             live_q;
  logic             done_q;
  logic             busy;

  logic [Cells-1:0] disp;
  logic             load_ok;
  logic             last_cell;
  logic [XW-1:0]    xs [3];
  logic [YW-1:0]    ys [3];
  logic [3:0]       ncount;
  logic             next_alive;

  function automatic logic [IdxW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IdxW'(32'(x) * P_PARAM_N + 32'(y));
  endfunction

  assign disp      = bank_q[disp_sel_q];
  assign load_ok   = bus.load_en && (bus.load_pos < CellsP);
  assign last_cell = (idx_q == IdxW'(Cells - 1));

  // Neighbour count of the current cell with toroidal wrap, and its next state.
  always_comb begin
    xs[0] = (cx_q == '0) ? XW'(P_PARAM_M - 1) : cx_q - XW'(1);
    xs[1] = cx_q;
    xs[2] = (cx_q == XW'(P_PARAM_M - 1)) ? '0 : cx_q + XW'(1);
    ys[0] = (cy_q == '0) ? YW'(P_PARAM_N - 1) : cy_q - YW'(1);
    ys[1] = cy_q;
    ys[2] = (cy_q == YW'(P_PARAM_N - 1)) ? '0 : cy_q + YW'(1);
    ncount = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(i == 1 && j == 1)) begin
          ncount = ncount + 4'(disp[cell_idx(xs[i], ys[j])]);
        end
      end
    end
    next_alive = (ncount == 4'd3) || (disp[idx_q] && (ncount == 4'd2));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state; a valid load in the same cycle wins over step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!load_ok && bus.step) state_d = StCompute;
      StCompute: if (last_cell) state_d = StSwap;
      StSwap:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Banks, scan counters, generation counter and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      disp_sel_q <= 1'b0;
      idx_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      gen_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == StSwap);
      unique case (state_q)
        StIdle: begin
          if (load_ok) bank_q[disp_sel_q][bus.load_pos[IdxW-1:0]] <= bus.load_val;
          idx_q <= '0;
          cx_q  <= '0;
          cy_q  <= '0;
        end
        StCompute: begin
          bank_q[~disp_sel_q][idx_q] <= next_alive;
          idx_q <= idx_q + IdxW'(1);
          // Scan order is y fastest, matching index x*N + y.
          if (cy_q == YW'(P_PARAM_N - 1)) begin
            cy_q <= '0;
            cx_q <= cx_q + XW'(1);
          end else begin
            cy_q <= cy_q + YW'(1);
          end
        end
        StSwap: begin
          disp_sel_q <= ~disp_sel_q;
          gen_q      <= gen_q + GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered display read; out-of-range indices read as dead.
  always_ff @(posedge clk) begin
    if (reset) live_q <= 1'b0;
    else       live_q <= (bus.pos < CellsP) && disp[bus.pos[IdxW-1:0]];
  end

  assign bus.vga_live   = live_q;
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.generation = gen_q;
endmodule
